// File: rtl/sum_block_accum_if.sv
// sum_block_accum_if
//   Handshake bundle between an upstream sum producer, the block
//   accumulator and the downstream consumer of block totals.
//   Ports (signals):
//     in_valid  : producer has a sum on in_data
//     in_ready  : accumulator can take in_data this cycle
//     in_data   : incoming unsigned sum, WIDTH bits
//     clear     : synchronous flush of the partial block
//     out_valid : out_data holds a completed block total
//     out_ready : consumer takes out_data this cycle
//     out_data  : block total, ACC_WIDTH bits
//     out_index : block sequence number, 8 bits
//   master drives the request side, slave is the accumulator.
interface sum_block_accum_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 10
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_data;
    logic                 clear;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_data;
    logic [7:0]           out_index;

    modport master (
        output in_valid, in_data, clear, out_ready,
        input  in_ready, out_valid, out_data, out_index
    );

    modport slave (
        input  in_valid, in_data, clear, out_ready,
        output in_ready, out_valid, out_data, out_index
    );
endinterface

// File: rtl/sum_block_accum.sv
// sum_block_accum
//   Accumulates COUNT consecutive accepted sums into one block total and
//   presents it on a registered valid/ready output. The next block keeps
//   filling while a total waits; input stalls only when a second block
//   would complete before the first total is taken.
//   Ports:
//     clock  : rising-edge clock
//     resetn : asynchronous active-low reset
//     bus    : sum_block_accum_if.slave (in/out handshakes, clear)
//
//   state            | meaning
//   -----------------+----------------------------------------------
//   PARTIAL          | cnt <  COUNT-1, accept adds into acc
//   LAST             | cnt == COUNT-1, accept completes the block
//   EMPTY            | out_valid = 0, no total pending
//   FULL             | out_valid = 1, out_data/out_index held stable
//   The states are implicit in (cnt, out_valid).
module sum_block_accum #(
    parameter int WIDTH     = 8,
    parameter int COUNT     = 4,
    parameter int ACC_WIDTH = 10
) (
    input  logic clock,
    input  logic resetn,
    sum_block_accum_if.slave bus
);
    localparam int CNT_W = (COUNT > 2) ? $clog2(COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_W-1:0]     cnt;
    logic [7:0]           blk_num;
    logic                 out_valid_q;
    logic [ACC_WIDTH-1:0] out_data_q;
    logic [7:0]           out_index_q;

    logic                 is_last;
    logic                 accept;
    logic                 complete;
    logic [ACC_WIDTH-1:0] acc_next;

    assign is_last  = (cnt == LAST_CNT);
    // Only a completing sample can collide with an untaken total.
    assign bus.in_ready = !(is_last && out_valid_q && !bus.out_ready);
    assign accept   = bus.in_valid && bus.in_ready && !bus.clear;
    assign complete = accept && is_last;
    assign acc_next = acc + ACC_WIDTH'(bus.in_data);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            acc         <= '0;
            cnt         <= '0;
            blk_num     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
        end else begin
            if (bus.clear) begin
                acc <= '0;
                cnt <= '0;
            end else if (accept) begin
                if (is_last) begin
                    acc         <= '0;
                    cnt         <= '0;
                    out_data_q  <= acc_next;
                    out_index_q <= blk_num;
                    blk_num     <= blk_num + 8'd1;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
                end
            end

            // A completion in the same cycle the old total is taken keeps
            // out_valid high, so back-to-back totals leave no bubble.
            if (complete) begin
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_index = out_index_q;
endmodule

// File: doc/sum_block_accum.md
Name: sum_block_accum

Overview:
- Downstream consumer of the registered adder stage's WIDTH-bit sum.
- Accepts one sum per valid/ready handshake and accumulates COUNT consecutive sums into a block total.
- Presents each block total on a registered valid/ready output.
- Keeps accepting the next block while the previous total waits; stalls only when a second total completes before the first is taken.

Parameters:
WIDTH, 8, width of each incoming sum.
COUNT, 4, samples per block; legal range 2..256.
ACC_WIDTH, 10, width of the block total; must be >= WIDTH + ceil(log2(COUNT)); otherwise the total wraps modulo 2^ACC_WIDTH.

Ports:
clock  input  1  rising-edge clock.
resetn  input  1  asynchronous active-low reset.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  block can accept in_data this cycle.
in_data  input  WIDTH  incoming sum, unsigned.
clear  input  1  synchronous flush of the partial block.
out_valid  output  1  out_data holds a completed block total.
out_ready  input  1  consumer accepts out_data this cycle.
out_data  output  ACC_WIDTH  block total, unsigned.
out_index  output  8  block sequence number, wraps 255->0.

Behaviour:
- Clock and reset: one clock, `clock`. Reset `resetn` is asynchronous and active-low.
- Reset values: acc=0, cnt=0, out_valid=0, out_data=0, out_index=0, internal blk_num=0.
- in_ready is combinational: in_ready = !(cnt==COUNT-1 && out_valid && !out_ready).
- Accept condition: accept = in_valid && in_ready. On accept, in_data is zero-extended to ACC_WIDTH and added to acc.
- Arithmetic: all additions are unsigned modulo 2^ACC_WIDTH. There is no saturation and no overflow flag.
- State is implicit in (cnt, out_valid); two processes:
  - Accumulator: states PARTIAL (cnt<COUNT-1) and LAST (cnt==COUNT-1).
    - PARTIAL + accept: acc<=acc+in_data, cnt<=cnt+1.
    - LAST + accept: out_data<=acc+in_data, out_index<=blk_num, blk_num<=blk_num+1, out_valid<=1, acc<=0, cnt<=0.
  - Output register: states EMPTY (out_valid=0) and FULL (out_valid=1).
    - FULL + out_ready with no simultaneous completion: out_valid<=0.
    - FULL + out_ready with simultaneous completion: out_valid stays 1 and new total/index load in the same edge. No bubble, no loss.
- Latency: the total appears on out_valid the cycle after the COUNT-th accepted sample.
- Throughput: sustains one sample per cycle while out_ready is high at least once every COUNT cycles.
- clear (synchronous, active-high):
  - Sets acc<=0, cnt<=0, and suppresses any accept in the same cycle. in_ready itself is not gated by clear; a sample presented with clear is dropped.
  - Does not touch out_valid, out_data, out_index or blk_num. A pending total is still delivered.
- Stability: while out_valid=1 && out_ready=0, out_data and out_index hold stable.
- Back-pressure: in_valid may drop at any time. acc and cnt hold while nothing is accepted.
- Reset mid-operation: asynchronous return to reset values. Any partial block and pending total are discarded.

Test Plan:
- Defaults, out_ready=1, stream 1,2,3,4 on consecutive cycles -> one cycle after the 4th, out_valid=1, out_data=10, out_index=0. Next stream 5,6,7,8 -> out_data=26, out_index=1.
- Stream 255,255,255,255 -> out_data=1020 (no wrap). With ACC_WIDTH=9, same stream -> out_data=508 (1020 mod 512).
- out_ready=0, stream 1..8 -> first total 10 held. in_ready drops while cnt==3 with block 2 pending (samples 5,6,7 accepted, 8 stalled). Raise out_ready -> 10 taken and 8 accepted in the same cycle. Next cycle out_data=26. No sample lost or duplicated.
- Send 9,9 then clear=1 with in_valid=1, in_data=50 -> 50 dropped and acc flushed. Then 1,1,1,1 -> out_data=4. blk_num is unchanged by the clear.
- Drop resetn low mid-block (cnt=2) and while out_valid=1 -> outputs go to zero immediately without a clock edge. After release, 2,2,2,2 -> out_data=8, out_index=0.
- Randomized in_valid/out_ready over 64 blocks against a reference model -> totals match and out_index increments by 1 each block, wrapping 255->0.
